// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the SPI target engine.
// No ports; imported by spi_target_engine_if, spi_sync_edge users and spi_target_engine.
package spi_pkg;
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} spi_tgt_state_t;
    localparam int SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_FILL_DEFAULT = 8'hFF;
endpackage

// File: rtl/spi_target_engine_if.sv
// spi_target_engine_if: byte-side host interface of the SPI target engine.
// slave modport (engine): drives rx_byte_o/rx_valid_o, tx_ready_o, tx_underrun_o,
//   frame_start_o/frame_end_o, busy_o, frame_bytes_o; receives tx_byte_i/tx_load_i.
// master modport (host logic): the mirror image.
interface spi_target_engine_if;
    import spi_pkg::*;
    logic [SPI_BYTE_W-1:0] rx_byte_o;
    logic                  rx_valid_o;
    logic [SPI_BYTE_W-1:0] tx_byte_i;
    logic                  tx_load_i;
    logic                  tx_ready_o;
    logic                  tx_underrun_o;
    logic                  frame_start_o;
    logic                  frame_end_o;
    logic                  busy_o;
    logic [15:0]           frame_bytes_o;
    modport slave (
        output rx_byte_o, rx_valid_o, tx_ready_o, tx_underrun_o,
               frame_start_o, frame_end_o, busy_o, frame_bytes_o,
        input  tx_byte_i, tx_load_i
    );
    modport master (
        input  rx_byte_o, rx_valid_o, tx_ready_o, tx_underrun_o,
               frame_start_o, frame_end_o, busy_o, frame_bytes_o,
        output tx_byte_i, tx_load_i
    );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer with synced level and rise/fall strobes.
// Ports: clk, reset (sync, active high), d_i (async input),
//   level_o (synced level), rise_o/fall_o (one-cycle edge strobes).
// RST_VAL sets the reset value of every stage and of the edge-history flop.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end
    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_target_engine.sv
// spi_target_engine: mode-0, MSB-first byte SPI target with a one-entry transmit holding register.
// Ports: clk, reset (sync, active high); spi_sck/spi_csb/spi_mosi (async pins in);
//   spi_miso/spi_miso_oe (pins out); host (spi_target_engine_if.slave byte interface).
// Optional macro SPI_TARGET_FRAME_COUNT_EN builds the saturating per-frame byte counter;
// without it frame_bytes_o is tied to zero.
module spi_target_engine
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_FILL   = SPI_IDLE_FILL_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_csb,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    spi_target_engine_if.slave host
);
    logic sck_rise, sck_fall, csb_lvl, csb_rise, csb_fall, mosi_lvl;
    logic sck_lvl_unused;
    logic [1:0] mosi_edge_unused;
    // csb resets to asserted so a frame already running at reset release is never seen as starting
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d_i(spi_sck),
        .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csb (
        .clk(clk), .reset(reset), .d_i(spi_csb),
        .level_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .d_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_edge_unused[0]), .fall_o(mosi_edge_unused[1]));

    spi_tgt_state_t        state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-2:0] rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d, hold_q, hold_d, rx_byte_q, rx_byte_d;
    logic bound_q, bound_d, full_q, full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic fstart_q, fstart_d, fend_q, fend_d, miso_q, miso_d, oe_q, oe_d;
    logic reload, shift;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        full_d     = full_q;
        rx_byte_d  = rx_byte_q;
        bound_d    = bound_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        fstart_d   = 1'b0;
        fend_d     = 1'b0;
        reload     = 1'b0;
        shift      = 1'b0;
        if (host.tx_load_i && !full_q) begin
            hold_d = host.tx_byte_i;
            full_d = 1'b1;
        end
        case (state_q)
            WAIT_IDLE: state_d = csb_lvl ? IDLE : WAIT_IDLE;
            IDLE: if (csb_fall) begin
                state_d   = SHIFT;
                fstart_d  = 1'b1;
                bit_cnt_d = '0;
                bound_d   = 1'b0;
                oe_d      = 1'b1;
                reload    = 1'b1;
            end
            SHIFT: if (csb_rise) begin
                // chip-select release beats any coincident sck edge
                state_d   = IDLE;
                fend_d    = 1'b1;
                oe_d      = 1'b0;
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                bound_d   = 1'b0;
            end else if (sck_rise) begin
                rx_shift_d = {rx_shift_q[SPI_BYTE_W-3:0], mosi_lvl};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_d  = {rx_shift_q, mosi_lvl};
                    rx_valid_d = 1'b1;
                    bound_d    = 1'b1;
                end
            end else if (sck_fall) begin
                reload  = bound_q;
                shift   = !bound_q;
                bound_d = 1'b0;
            end
            default: state_d = WAIT_IDLE;
        endcase
        // a load accepted this cycle only reaches hold_d, so an empty register still shifts IDLE_FILL
        if (reload) begin
            tx_shift_d = full_q ? hold_q : IDLE_FILL;
            underrun_d = !full_q;
            if (full_q) full_d = 1'b0;
        end
        if (shift) tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
        if (reload || shift) miso_d = tx_shift_d[SPI_BYTE_W-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            rx_byte_q  <= '0;
            bound_q    <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            fstart_q   <= 1'b0;
            fend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            rx_byte_q  <= rx_byte_d;
            bound_q    <= bound_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            fstart_q   <= fstart_d;
            fend_q     <= fend_d;
        end
    end

`ifdef SPI_TARGET_FRAME_COUNT_EN
    logic [15:0] fbytes_q, fbytes_d;
    assign fbytes_d = fstart_d ? 16'h0000 :
                      (rx_valid_d && fbytes_q != 16'hFFFF) ? fbytes_q + 16'd1 : fbytes_q;
    always_ff @(posedge clk) begin
        if (reset) fbytes_q <= '0;
        else fbytes_q <= fbytes_d;
    end
    assign host.frame_bytes_o = fbytes_q;
`else
    assign host.frame_bytes_o = 16'h0000;
`endif

    assign spi_miso           = miso_q;
    assign spi_miso_oe        = oe_q;
    assign host.rx_byte_o     = rx_byte_q;
    assign host.rx_valid_o    = rx_valid_q;
    assign host.tx_ready_o    = !full_q;
    assign host.tx_underrun_o = underrun_q;
    assign host.frame_start_o = fstart_q;
    assign host.frame_end_o   = fend_q;
    assign host.busy_o        = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_target_engine.sv
// tb_spi_target_engine: directed and randomized SPI frames against a byte-level reference model.
module tb_spi_target_engine;
    logic clk, reset, spi_sck, spi_csb, spi_mosi, spi_miso, spi_miso_oe;
    spi_target_engine_if ifc();

    spi_target_engine #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .spi_sck(spi_sck), .spi_csb(spi_csb), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .host(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_rxv = 0, n_und = 0, n_fs = 0, n_fe = 0;
    logic [7:0] rxq[$];
    logic [7:0] mo [8];
    logic [7:0] mi [8];
    logic [7:0] exp_mi [8];
    logic       m_full;
    logic [7:0] m_hold;

    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.rx_valid_o) begin
                n_rxv++;
                rxq.push_back(ifc.rx_byte_o);
            end
            if (ifc.tx_underrun_o) n_und++;
            if (ifc.frame_start_o) n_fs++;
            if (ifc.frame_end_o) n_fe++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] v);
        check("ready_before_load", ifc.tx_ready_o, !m_full);
        if (!m_full) begin
            m_hold = v;
            m_full = 1'b1;
        end
        ifc.tx_byte_i = v;
        ifc.tx_load_i = 1'b1;
        wait_clk(1);
        ifc.tx_load_i = 1'b0;
        wait_clk(1);
    endtask

    task automatic clock_bits(input int k, input int half);
        for (int i = 0; i < k; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            wait_clk(half);
            spi_sck = 1'b1;
            wait_clk(half);
            spi_sck = 1'b0;
        end
    endtask

    // Master side: mode 0, MOSI changes with SCK low, MISO sampled just before each SCK rise.
    // The final SCK fall coincides with CSB release; load_at+1 names the byte whose boundary gets a tx_load.
    task automatic frame(input int n, input int bits_last, input int half, input int load_at, input logic [7:0] load_val);
        int nb;
        spi_csb  = 1'b0;
        spi_mosi = mo[0][7];
        wait_clk(2);
        check("frame_start_early", ifc.frame_start_o, 0);
        wait_clk(1);
        check("frame_start_latency", ifc.frame_start_o, 1);
        wait_clk(half - 3);
        check("miso_oe_on", spi_miso_oe, 1);
        check("busy_on", ifc.busy_o, 1);
        for (int b = 0; b < n; b++) begin
            nb = (b == n - 1) ? bits_last : 8;
            mi[b] = 8'h00;
            for (int k = 0; k < nb; k++) begin
                if (b != 0 || k != 0) begin
                    spi_mosi = mo[b][7-k];
                    if (k == 0 && b == load_at + 1) begin
                        wait_clk(2);
                        ifc.tx_byte_i = load_val;
                        ifc.tx_load_i = 1'b1;
                        wait_clk(1);
                        ifc.tx_load_i = 1'b0;
                        wait_clk(half - 3);
                    end else wait_clk(half);
                end
                mi[b] = {mi[b][6:0], spi_miso};
                spi_sck = 1'b1;
                wait_clk(half);
                spi_sck = 1'b0;
                if (b == n - 1 && k == nb - 1) spi_csb = 1'b1;
            end
        end
        wait_clk(2);
        check("frame_end_early", ifc.frame_end_o, 0);
        wait_clk(1);
        check("frame_end_latency", ifc.frame_end_o, 1);
        wait_clk(4);
    endtask

    // Reference: each started byte takes the holding register (or 0xFF with an underrun);
    // a load at a boundary lands only if the register was empty before that take.
    task automatic run(input int n, input int bits_last, input int half, input int load_at, input logic [7:0] load_val);
        int und0, fs0, fe0, done, exp_und, nb, exp_fb;
        logic was_full;
        done    = (bits_last == 8) ? n : n - 1;
        exp_und = 0;
        for (int b = 0; b < n; b++) begin
            was_full = m_full;
            if (m_full) begin
                exp_mi[b] = m_hold;
                m_full    = 1'b0;
            end else begin
                exp_mi[b] = 8'hFF;
                exp_und++;
            end
            if (b != 0 && b == load_at + 1 && !was_full) begin
                m_hold = load_val;
                m_full = 1'b1;
            end
        end
`ifdef SPI_TARGET_FRAME_COUNT_EN
        exp_fb = done;
`else
        exp_fb = 0;
`endif
        und0 = n_und;
        fs0  = n_fs;
        fe0  = n_fe;
        rxq.delete();
        frame(n, bits_last, half, load_at, load_val);
        for (int b = 0; b < n; b++) begin
            nb = (b == n - 1) ? bits_last : 8;
            check("miso_byte", mi[b], exp_mi[b] >> (8 - nb));
        end
        check("rx_valid_count", rxq.size(), done);
        for (int i = 0; i < done && i < rxq.size(); i++) check("rx_byte", rxq[i], mo[i]);
        if (done > 0) check("rx_byte_held", ifc.rx_byte_o, mo[done-1]);
        check("underruns", n_und - und0, exp_und);
        check("frame_starts", n_fs - fs0, 1);
        check("frame_ends", n_fe - fe0, 1);
        check("frame_bytes", ifc.frame_bytes_o, exp_fb);
        check("miso_oe_off", spi_miso_oe, 0);
        check("miso_off", spi_miso, 0);
        check("busy_off", ifc.busy_o, 0);
        check("tx_ready_after", ifc.tx_ready_o, !m_full);
    endtask

    initial begin
        int n, fs0, fe0, rx0, half, bits_last, load_at;
        reset         = 1'b1;
        spi_sck       = 1'b0;
        spi_csb       = 1'b1;
        spi_mosi      = 1'b0;
        ifc.tx_byte_i = 8'h00;
        ifc.tx_load_i = 1'b0;
        m_full        = 1'b0;
        m_hold        = 8'h00;
        wait_clk(3);
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_rx_byte", ifc.rx_byte_o, 0);
        check("rst_rx_valid", ifc.rx_valid_o, 0);
        check("rst_underrun", ifc.tx_underrun_o, 0);
        check("rst_frame_start", ifc.frame_start_o, 0);
        check("rst_frame_end", ifc.frame_end_o, 0);
        check("rst_busy", ifc.busy_o, 0);
        check("rst_frame_bytes", ifc.frame_bytes_o, 0);
        check("rst_tx_ready", ifc.tx_ready_o, 1);
        reset = 1'b0;
        wait_clk(6);

        // single byte with preloaded reply; second load while full is dropped
        preload(8'hA5);
        preload(8'h5A);
        mo[0] = 8'h3C;
        run(1, 8, 6, -1, 8'h00);

        // three bytes, one reply preloaded
        preload(8'h11);
        for (int i = 0; i < 3; i++) mo[i] = 8'($urandom);
        run(3, 8, 5, -1, 8'h00);

        // aborted partial byte, then a clean frame
        mo[0] = 8'($urandom);
        run(1, 5, 5, -1, 8'h00);
        mo[0] = 8'h81;
        run(1, 8, 5, -1, 8'h00);

        // reset in the middle of a frame, released with CSB still low
        preload(8'h77);
        spi_csb = 1'b0;
        wait_clk(5);
        clock_bits(3, 5);
        reset = 1'b1;
        wait_clk(2);
        check("reset_mid_oe", spi_miso_oe, 0);
        reset  = 1'b0;
        m_full = 1'b0;
        fs0 = n_fs;
        fe0 = n_fe;
        rx0 = n_rxv;
        clock_bits(8, 5);
        check("post_reset_oe", spi_miso_oe, 0);
        check("post_reset_busy", ifc.busy_o, 0);
        check("post_reset_no_start", n_fs - fs0, 0);
        check("post_reset_no_rx", n_rxv - rx0, 0);
        spi_csb = 1'b1;
        wait_clk(8);
        check("post_reset_no_end", n_fe - fe0, 0);
        check("post_reset_ready", ifc.tx_ready_o, 1);
        for (int i = 0; i < 2; i++) mo[i] = 8'($urandom);
        run(2, 8, 5, -1, 8'h00);

        // load arriving in the same cycle as an underrun boundary load
        preload(8'hC3);
        for (int i = 0; i < 3; i++) mo[i] = 8'($urandom);
        run(3, 8, 5, 0, 8'h55);

        // minimum SCK high/low time, four back-to-back bytes
        preload(8'($urandom));
        for (int i = 0; i < 4; i++) mo[i] = 8'($urandom);
        run(4, 8, 4, -1, 8'h00);

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            n         = $urandom_range(1, 4);
            half      = $urandom_range(4, 7);
            bits_last = (r % 4 == 3) ? $urandom_range(1, 7) : 8;
            load_at   = $urandom_range(0, n) - 1;
            if ($urandom_range(0, 1) == 1) preload(8'($urandom));
            for (int i = 0; i < n; i++) mo[i] = 8'($urandom);
            run(n, bits_last, half, load_at, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
